// File: rtl/spi_lane_engine.sv
// SPI master shift engine: serialises one right-aligned frame of 8/16/24/32
// bits over 1, 2 or 4 IO lanes with CPOL/CPHA, MSB/LSB order, a programmable
// SCK divider and chip-select handling. Frames can run back-to-back with CS
// held. The RX side is a single holding register with valid/ready
// backpressure, and the engine waits in WAIT_RX rather than drop a frame.
module spi_lane_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NSS_NUM    = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [1:0]            spm_i,
    input  logic [1:0]            tdtb_i,
    input  logic                  rwm_i,
    input  logic                  ass_i,
    input  logic [NSS_NUM-1:0]    nss_sel_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  spi_sck_o,
    output logic [NSS_NUM-1:0]    spi_nss_o,
    output logic [3:0]            spi_io_en_o,
    output logic [3:0]            spi_io_out_o,
    input  logic [3:0]            spi_io_in_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_WAIT_RX
    } state_t;

    // Next beat to drive, taken from the edge of the shift register that
    // matches the bit order. MSB-first: the top lane carries the highest bit.
    function automatic logic [3:0] f_beat(input logic [DATA_WIDTH-1:0] sr,
                                          input logic [1:0] lsh,
                                          input logic lsb);
        logic [3:0] b;
        b = 4'b0000;
        case (lsh)
            2'd0:    b[0]   = lsb ? sr[0]   : sr[DATA_WIDTH-1];
            2'd1:    b[1:0] = lsb ? sr[1:0] : sr[DATA_WIDTH-1 -: 2];
            default: b      = lsb ? sr[3:0] : sr[DATA_WIDTH-1 -: 4];
        endcase
        return b;
    endfunction

    // Drop the beat just driven (lanes = 1 << lsh bits).
    function automatic logic [DATA_WIDTH-1:0] f_shift(input logic [DATA_WIDTH-1:0] sr,
                                                      input logic [1:0] lsh,
                                                      input logic lsb);
        int n;
        n = 1 << lsh;
        return lsb ? (sr >> n) : (sr << n);
    endfunction

    // Frame state
    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [5:0]            r_half;
    logic [5:0]            r_last_half;
    logic [5:0]            r_nbits;
    logic [1:0]            r_lsh;
    logic                  r_cpha;
    logic                  r_lsb;
    logic                  r_ass;
    logic                  r_sck;
    logic [NSS_NUM-1:0]    r_nss;
    logic [3:0]            r_io_en;
    logic [3:0]            r_io_out;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;

    // Decode of the live configuration, used only at frame acceptance
    logic [1:0]            w_lsh;
    logic [5:0]            w_nbits;
    logic [5:0]            w_beats;
    logic [5:0]            w_last_half;
    logic [3:0]            w_io_en;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_tx_align;

    assign w_lsh       = spm_i[1] ? 2'd2 : (spm_i[0] ? 2'd1 : 2'd0);
    assign w_nbits     = {({1'b0, tdtb_i} + 3'd1), 3'b000};
    assign w_beats     = w_nbits >> w_lsh;
    // 32 beats wraps to 0 before the decrement, giving 63 as required.
    assign w_last_half = (w_beats << 1) - 6'd1;
    assign w_mask      = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(w_nbits));
    // MSB-first frames are left-aligned so the top bit leaves first;
    // LSB-first frames stay right-aligned with the unused bits cleared.
    assign w_tx_align  = lsb_i ? (tx_data_i & w_mask)
                               : (tx_data_i << (DATA_WIDTH - int'(w_nbits)));

    // Lane output enables: std drives MOSI only; dual/quad follow rwm.
    always_comb begin
        w_io_en = 4'b0000;
        case (w_lsh)
            2'd0:    w_io_en = 4'b0001;
            2'd1:    w_io_en = rwm_i ? 4'b0000 : 4'b0011;
            default: w_io_en = rwm_i ? 4'b0000 : 4'b1111;
        endcase
    end

    // Receive path: gather the sampled lanes (MISO is io1 in std mode).
    logic [3:0]            w_s;
    int                    w_rl;
    logic [DATA_WIDTH-1:0] w_rx_shift;
    logic [DATA_WIDTH-1:0] w_rx_final;

    always_comb begin
        w_s = 4'b0000;
        case (r_lsh)
            2'd0:    w_s[0]   = spi_io_in_i[1];
            2'd1:    w_s[1:0] = spi_io_in_i[1:0];
            default: w_s      = spi_io_in_i;
        endcase
    end

    assign w_rl       = 1 << r_lsh;
    assign w_rx_shift = r_lsb ? ((r_rx >> w_rl) | (DATA_WIDTH'(w_s) << (DATA_WIDTH - w_rl)))
                              : ((r_rx << w_rl) | DATA_WIDTH'(w_s));
    // LSB-first data accumulates at the top and is right-aligned on delivery.
    assign w_rx_final = r_lsb ? (r_rx >> (DATA_WIDTH - int'(r_nbits))) : r_rx;

    // Handshake decode
    logic w_half_end;
    logic w_sample_edge;
    logic w_rx_free;
    logic w_frame_end;
    logic w_accept;

    assign w_half_end    = (r_cnt == r_div);
    // Even half-period ends are leading edges, odd ones trailing.
    assign w_sample_edge = (r_half[0] == r_cpha);
    assign w_rx_free     = ~r_rx_valid | rx_ready_i;
    assign w_frame_end   = ((r_state == S_HOLD) & w_half_end & w_rx_free) |
                           ((r_state == S_WAIT_RX) & rx_ready_i);
    assign tx_ready_o    = ~rst_i & en_i &
                           (((r_state == S_IDLE) & ~r_rx_valid) | w_frame_end);
    assign w_accept      = tx_valid_i & tx_ready_o;

    // Main FSM: SCK timing, lane shifting, RX delivery and CS control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_half      <= '0;
            r_last_half <= '0;
            r_nbits     <= '0;
            r_lsh       <= '0;
            r_cpha      <= 1'b0;
            r_lsb       <= 1'b0;
            r_ass       <= 1'b0;
            r_sck       <= 1'b0;
            r_nss       <= '1;
            r_io_en     <= '0;
            r_io_out    <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            if (r_rx_valid && rx_ready_i)
                r_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: ;
                S_SETUP: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        r_sck <= ~r_sck;
                        if (w_sample_edge) begin
                            r_rx <= w_rx_shift;
                        end else begin
                            r_io_out <= f_beat(r_tx, r_lsh, r_lsb);
                            r_tx     <= f_shift(r_tx, r_lsh, r_lsb);
                        end
                        if (r_half == r_last_half)
                            r_state <= S_HOLD;
                        else
                            r_half <= r_half + 6'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!w_rx_free)
                            r_state <= S_WAIT_RX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_RX: ;
                default: r_state <= S_IDLE;
            endcase

            // Deliver the frame and release the bus; an accept below
            // overrides the release so CS stays low for the next frame.
            if (w_frame_end) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_rx_final;
                r_state    <= S_IDLE;
                r_nss      <= '1;
                r_io_en    <= '0;
                r_io_out   <= '0;
            end

            if (w_accept) begin
                r_state     <= S_SETUP;
                r_cnt       <= '0;
                r_half      <= '0;
                r_div       <= div_i;
                r_last_half <= w_last_half;
                r_nbits     <= w_nbits;
                r_lsh       <= w_lsh;
                r_cpha      <= cpha_i;
                r_lsb       <= lsb_i;
                r_ass       <= ass_i;
                r_sck       <= cpol_i;
                r_nss       <= ass_i ? ~nss_sel_i : '1;
                r_io_en     <= w_io_en;
                r_rx        <= '0;
                // With cpha=0 the first beat must be on the lines before
                // the leading edge; with cpha=1 it goes out on that edge.
                if (cpha_i) begin
                    r_io_out <= 4'b0000;
                    r_tx     <= w_tx_align;
                end else begin
                    r_io_out <= f_beat(w_tx_align, w_lsh, lsb_i);
                    r_tx     <= f_shift(w_tx_align, w_lsh, lsb_i);
                end
            end
        end
    end

    // Outputs: SCK follows cpol while idle; manual CS is a straight pass-through.
    logic w_ass_eff;
    assign w_ass_eff    = (r_state == S_IDLE) ? ass_i : r_ass;
    assign spi_sck_o    = (r_state == S_IDLE) ? cpol_i : r_sck;
    assign spi_nss_o    = w_ass_eff ? r_nss : ~nss_sel_i;
    assign spi_io_en_o  = r_io_en;
    assign spi_io_out_o = r_io_out;
    assign busy_o       = (r_state != S_IDLE);
    assign rx_valid_o   = r_rx_valid;
    assign rx_data_o    = r_rx_data;

endmodule

// File: tb/tb_spi_lane_engine.sv
// Directed bench for spi_lane_engine: a table of single-frame vectors with
// loopback or a quad slave model, plus hand sequences for reset mid-frame,
// back-to-back frames under RX backpressure, and enable drop while busy.
module tb_spi_lane_engine;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i, cpol_i, cpha_i, lsb_i, rwm_i, ass_i;
    logic [1:0]  spm_i, tdtb_i;
    logic [3:0]  nss_sel_i;
    logic [15:0] div_i;
    logic        tx_valid_i, tx_ready_o;
    logic [31:0] tx_data_i;
    logic        rx_valid_o, rx_ready_i;
    logic [31:0] rx_data_o;
    logic        busy_o, spi_sck_o;
    logic [3:0]  spi_nss_o, spi_io_en_o, spi_io_out_o, spi_io_in_i;

    logic [1:0]  loop_mode;   // 0 slave model, 1 std io0->io1, 2 lane loopback
    logic [3:0]  slv_io;

    always #5 clk = ~clk;

    assign spi_io_in_i = (loop_mode == 2'd1) ? {2'b00, spi_io_out_o[0], 1'b0} :
                         (loop_mode == 2'd2) ? spi_io_out_o : slv_io;

    spi_lane_engine #(.DATA_WIDTH(32), .NSS_NUM(4), .DIV_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .lsb_i(lsb_i), .spm_i(spm_i), .tdtb_i(tdtb_i), .rwm_i(rwm_i), .ass_i(ass_i),
        .nss_sel_i(nss_sel_i), .div_i(div_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .busy_o(busy_o),
        .spi_sck_o(spi_sck_o), .spi_nss_o(spi_nss_o), .spi_io_en_o(spi_io_en_o),
        .spi_io_out_o(spi_io_out_o), .spi_io_in_i(spi_io_in_i)
    );

    typedef struct {
        logic [1:0]  spm, tdtb;
        logic        lsb, cpol, cpha, rwm, ass;
        logic [3:0]  sel;
        logic [15:0] div;
        logic [31:0] tx;
        logic [1:0]  loopm;
        logic [31:0] slv;          // slave word, left-aligned, quad MSB-first
        logic [31:0] exp_rx;
        logic [3:0]  exp_en, exp_nss_busy, exp_nss_idle, exp_first, exp_last;
        int          exp_beats, exp_lat;
        logic        chk_beats;
    } vec_t;

    vec_t vt[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Run one frame from acceptance to RX retirement, tracking SCK edges.
    task automatic run_frame(input vec_t v, input int idx);
        logic [3:0] q[$];
        logic       prev, leading, samp, got, ok, busy_mid;
        logic [3:0] en_mid, nss_mid;
        int         n, k;
        @(negedge clk);
        spm_i = v.spm; tdtb_i = v.tdtb; lsb_i = v.lsb; cpol_i = v.cpol;
        cpha_i = v.cpha; rwm_i = v.rwm; ass_i = v.ass; nss_sel_i = v.sel;
        div_i = v.div; tx_data_i = v.tx; loop_mode = v.loopm;
        k = 0;
        if (!v.cpha) begin slv_io = v.slv[31:28]; k = 1; end
        tx_valid_i = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (tx_ready_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk($sformatf("v%0d_accept", idx), {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        prev = spi_sck_o; n = 0; got = 1'b0;
        en_mid = '0; nss_mid = '0; busy_mid = 1'b0;
        while (n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (spi_sck_o !== prev) begin
                leading = (spi_sck_o !== v.cpol);
                samp    = v.cpha ? !leading : leading;
                if (samp) q.push_back(spi_io_out_o);
                else if (k < 8) begin slv_io = v.slv[31-4*k -: 4]; k++; end
                prev = spi_sck_o;
            end
            if (n == 2) begin en_mid = spi_io_en_o; nss_mid = spi_nss_o; busy_mid = busy_o; end
            if (rx_valid_o) begin got = 1'b1; break; end
        end
        chk($sformatf("v%0d_rx_seen", idx), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
        chk($sformatf("v%0d_rx_data", idx), rx_data_o, v.exp_rx);
        chk($sformatf("v%0d_io_en", idx), en_mid, v.exp_en);
        chk($sformatf("v%0d_nss_busy", idx), nss_mid, v.exp_nss_busy);
        chk($sformatf("v%0d_busy_mid", idx), busy_mid, 1);
        chk($sformatf("v%0d_beats", idx), q.size(), v.exp_beats);
        if (v.chk_beats && q.size() > 0) begin
            chk($sformatf("v%0d_first_beat", idx), q[0], v.exp_first);
            chk($sformatf("v%0d_last_beat", idx), q[q.size()-1], v.exp_last);
        end
        if (idx == 0 && q.size() == 8) begin
            logic [7:0] seq;
            seq = 8'b10100101;
            for (int b = 0; b < 8; b++)
                chk($sformatf("v0_io0_bit%0d", b), q[b][0], seq[7-b]);
        end
        @(negedge clk); rx_ready_i = 1'b1;
        @(posedge clk); #1;
        rx_ready_i = 1'b0;
        chk($sformatf("v%0d_rx_retired", idx), rx_valid_o, 0);
        chk($sformatf("v%0d_idle_busy", idx), busy_o, 0);
        chk($sformatf("v%0d_idle_nss", idx), spi_nss_o, v.exp_nss_idle);
        chk($sformatf("v%0d_idle_sck", idx), spi_sck_o, v.cpol);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_ready"}, tx_ready_o, 0);
        chk({tag, "_rx_valid"}, rx_valid_o, 0);
        chk({tag, "_rx_data"}, rx_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_sck"}, spi_sck_o, 0);
        chk({tag, "_nss"}, spi_nss_o, 4'hF);
        chk({tag, "_io_en"}, spi_io_en_o, 0);
        chk({tag, "_io_out"}, spi_io_out_o, 0);
    endtask

    initial begin
        logic nss_rose, ok;
        // spm tdtb lsb cpol cpha rwm ass sel div tx loop slv exp_rx en nssB nssI first last beats lat chk
        vt[0] = '{2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 16'd0, 32'h0000_00A5,
                  2'd1, 32'h0, 32'h0000_00A5, 4'b0001, 4'b1110, 4'b1111, 4'h1, 4'h1, 8, 18, 1'b1};
        vt[1] = '{2'b10, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 16'd3, 32'h1234_5678,
                  2'd2, 32'h0, 32'h1234_5678, 4'b1111, 4'b1110, 4'b1111, 4'h8, 4'h1, 8, 72, 1'b1};
        vt[2] = '{2'b10, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 16'd1, 32'h0,
                  2'd0, 32'hBEEF_0000, 32'h0000_BEEF, 4'b0000, 4'b1110, 4'b1111, 4'h0, 4'h0, 4, 20, 1'b0};
        vt[3] = '{2'b01, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 16'd2, 32'h0000_C3A5,
                  2'd2, 32'h0, 32'h0000_C3A5, 4'b0011, 4'b1110, 4'b1111, 4'h3, 4'h1, 8, 54, 1'b1};
        vt[4] = '{2'b00, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 16'd0, 32'hFFAB_CDEF,
                  2'd1, 32'h0, 32'h00AB_CDEF, 4'b0001, 4'b1110, 4'b1111, 4'h1, 4'h1, 24, 50, 1'b1};
        vt[5] = '{2'b01, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 16'd0, 32'h0000_0096,
                  2'd2, 32'h0, 32'h0000_0096, 4'b0011, 4'b1010, 4'b1010, 4'h2, 4'h2, 4, 10, 1'b1};

        rst_i = 1'b1; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
        spm_i = 2'b00; tdtb_i = 2'd0; rwm_i = 1'b0; ass_i = 1'b1; nss_sel_i = 4'b0001;
        div_i = 16'd0; tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
        loop_mode = 2'd1; slv_io = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(vt[i], i);

        // Reset in the middle of a 24-bit std frame
        @(negedge clk);
        spm_i = 2'b00; tdtb_i = 2'd2; lsb_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
        ass_i = 1'b1; nss_sel_i = 4'b0001; div_i = 16'd1; tx_data_i = 32'h00C0FFEE;
        loop_mode = 2'd1; tx_valid_i = 1'b1;
        @(posedge clk); #1; tx_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_busy", busy_o, 1);
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        @(negedge clk); rst_i = 1'b0;
        run_frame(vt[0], 6);

        // Back-to-back std frames with RX held off
        @(negedge clk);
        spm_i = 2'b00; tdtb_i = 2'd0; lsb_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
        ass_i = 1'b1; nss_sel_i = 4'b0001; div_i = 16'd0; loop_mode = 2'd1;
        tx_data_i = 32'h11; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        tx_data_i = 32'h22;
        nss_rose = 1'b0; ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (spi_nss_o[0]) nss_rose = 1'b1;
            if (tx_ready_o) begin ok = 1'b1; break; end
        end
        chk("b2b_second_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            if (spi_nss_o[0]) nss_rose = 1'b1;
        end
        chk("b2b_cs_held", nss_rose, 0);
        chk("b2b_stall_busy", busy_o, 1);
        chk("b2b_stall_sck", spi_sck_o, 0);
        chk("b2b_first_valid", rx_valid_o, 1);
        chk("b2b_first_data", rx_data_o, 32'h11);
        @(negedge clk); rx_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("b2b_second_valid", rx_valid_o, 1);
        chk("b2b_second_data", rx_data_o, 32'h22);
        chk("b2b_idle_busy", busy_o, 0);
        @(posedge clk); #1;
        rx_ready_i = 1'b0;
        chk("b2b_drained", rx_valid_o, 0);
        chk("b2b_cs_released", spi_nss_o, 4'hF);

        // Enable dropped mid-frame: frame finishes, no further accept
        @(negedge clk);
        tx_data_i = 32'h5A; tx_valid_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (rx_valid_o) begin ok = 1'b1; break; end
        end
        chk("en_rx_seen", {31'd0, ok}, 32'd1);
        chk("en_rx_data", rx_data_o, 32'h5A);
        chk("en_idle_busy", busy_o, 0);
        chk("en_cs_released", spi_nss_o, 4'hF);
        @(posedge clk); #1;
        chk("en_no_ready", tx_ready_o, 0);
        chk("en_still_idle", busy_o, 0);
        tx_valid_i = 1'b0; en_i = 1'b1; rx_ready_i = 1'b1;
        @(posedge clk); #1;
        rx_ready_i = 1'b0;
        chk("en_rx_retired", rx_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
